// File: rtl/gray_pkg.sv
// Shared helpers for the Gray-to-binary scheduler: converter function and ID width rule.
package gray_pkg;

    localparam int GRAY_MAX_W = 64;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Prefix XOR from the MSB down; callers zero-extend narrower codes, which leaves the low bits exact.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int k = GRAY_MAX_W - 2; k >= 0; k--) begin
            b[k] = b[k+1] ^ g[k];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_conv_scheduler_gray2bin_comb.sv
// Purely combinational Gray-to-binary converter of configurable width (up to GRAY_MAX_W).
module gray2bin_comb
    import gray_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0] gray,
    output logic [DATA_WIDTH-1:0] bin
);

    assign bin = DATA_WIDTH'(gray2bin(GRAY_MAX_W'(gray)));

endmodule

// File: rtl/gray_conv_scheduler.sv
// Round-robin scheduler sharing one Gray-to-binary converter among NUM_REQ requesters.
module gray_conv_scheduler
    import gray_pkg::*;
#(
    parameter  int DATA_WIDTH = 16,
    parameter  int NUM_REQ    = 4,
    localparam int ID_W       = id_width(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_gray,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_bin,
    output logic [ID_W-1:0]               out_id
);

    logic [ID_W-1:0]       rr_ptr;
    logic [NUM_REQ-1:0]    rot_p0;
    logic                  found_p0;
    logic                  grant_p0;
    logic                  slot_free;
    int                    off_p0;
    int                    idx_int_p0;
    int                    nxt_int_p0;
    logic [ID_W-1:0]       gnt_idx_p0;
    logic [ID_W-1:0]       rr_nxt_p0;
    logic [DATA_WIDTH-1:0] gray_p0;
    logic [DATA_WIDTH-1:0] bin_p0;

    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] bin_p1;
    logic [ID_W-1:0]       id_p1;

    assign slot_free = !vld_p1 || out_ready;

    // Stage p0: rotate valids by rr_ptr, take the lowest set bit, rotate the index back
    always_comb begin
        rot_p0     = NUM_REQ'({req_valid, req_valid} >> rr_ptr);
        found_p0   = 1'b0;
        off_p0     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found_p0 && rot_p0[i]) begin
                found_p0 = 1'b1;
                off_p0   = i;
            end
        end
        idx_int_p0 = int'(rr_ptr) + off_p0;
        if (idx_int_p0 >= NUM_REQ) idx_int_p0 = idx_int_p0 - NUM_REQ;
        nxt_int_p0 = idx_int_p0 + 1;
        if (nxt_int_p0 >= NUM_REQ) nxt_int_p0 = 0;
        gnt_idx_p0 = ID_W'(idx_int_p0);
        rr_nxt_p0  = ID_W'(nxt_int_p0);
        grant_p0   = found_p0 && slot_free && !reset;
        req_ready  = '0;
        if (grant_p0) req_ready[idx_int_p0] = 1'b1;
        gray_p0    = req_gray[idx_int_p0*DATA_WIDTH +: DATA_WIDTH];
    end

    gray2bin_comb #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_conv (
        .gray(gray_p0),
        .bin (bin_p0)
    );

    // Stage p1: output register; a new grant replaces a retiring result without a bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1 <= 1'b0;
            bin_p1 <= '0;
            id_p1  <= '0;
            rr_ptr <= '0;
        end else if (grant_p0) begin
            vld_p1 <= 1'b1;
            bin_p1 <= bin_p0;
            id_p1  <= gnt_idx_p0;
            rr_ptr <= rr_nxt_p0;
        end else if (out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign out_valid = vld_p1;
    assign out_bin   = bin_p1;
    assign out_id    = id_p1;

endmodule
